// File: rtl/fire_pkg.sv
// Shared constants, FSM states and the forward syndrome step for the Fire-code decoder.
// Generator g(x) = x^24+x^19+x^15+x^9+x^4+1; G holds its low 24 coefficients.
package fire_pkg;

   localparam int N = 64;
   localparam int K = 40;
   localparam int R = N - K;
   localparam int B = 8;
   localparam logic [R-1:0] G = 24'h088211;

   typedef enum logic [1:0] {
      IDLE,
      SYND,
      TRAP,
      DONE
   } state_t;

   // Long division step: after all N bits, S equals cw(x) mod g(x), so an error e leaves S = e mod g.
   function automatic logic [R-1:0] syn_step(input logic [R-1:0] s, input logic d);
      return {s[R-2:0], d} ^ (s[R-1] ? G : '0);
   endfunction

endpackage

// File: rtl/fire_syndrome.sv
// 24-bit syndrome register: clears, divides forward one bit at a time,
// or steps backwards by x^-1 mod g(x) while trapping a burst.
module fire_syndrome
   import fire_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         shift,
   input  logic         d,
   input  logic         unshift,
   output logic [R-1:0] s
);

   logic [R-1:0] unstep;

   // Multiplying by x^-1: add g when the constant term is set, then drop one degree.
   assign unstep = s[0] ? {1'b1, s[R-1:1] ^ G[R-1:1]} : {1'b0, s[R-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s <= '0;
      end else if (clr) begin
         s <= '0;
      end else if (shift) begin
         s <= syn_step(s, d);
      end else if (unshift) begin
         s <= unstep;
      end
   end

endmodule

// File: rtl/fire_decoder.sv
// Bit-serial Fire-code decoder: computes the syndrome of a 64-bit codeword, traps
// a burst of up to B bits, and returns the corrected payload with error status.
module fire_decoder
   import fire_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] cw_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [K-1:0] data_out,
   output logic         corrected,
   output logic         uncorrectable,
   output logic [5:0]   err_pos,
   output logic [B-1:0] err_burst
);

   state_t         state;
   state_t         next_state;
   logic [N-1:0]   cw_buf;
   logic [6:0]     cnt;
   logic [5:0]     j;
   logic [R-1:0]   syn;
   logic           syn_clr;
   logic           syn_shift;
   logic           syn_unshift;
   logic [N+B-1:0] burst_ext;
   logic [N-1:0]   fix;
   logic           hit;
   logic           clean;
   logic           last_trap;

   fire_syndrome u_syndrome (
      .clk     (clk),
      .rst     (rst),
      .clr     (syn_clr),
      .shift   (syn_shift),
      .d       (cw_buf[~cnt[5:0]]),
      .unshift (syn_unshift),
      .s       (syn)
   );

   // A burst placed at step j must lie entirely inside the codeword to count as a hit.
   assign burst_ext = {{N{1'b0}}, syn[B-1:0]} << j;
   assign fix       = burst_ext[N-1:0];
   assign hit       = (syn[R-1:B] == '0) && (burst_ext[N+B-1:N] == '0);
   assign clean     = (syn == '0) && (j == '0);
   assign last_trap = (j == 6'(N-1));

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      syn_clr     = 1'b0;
      syn_shift   = 1'b0;
      syn_unshift = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               next_state = SYND;
               syn_clr    = 1'b1;
            end
         end
         SYND: begin
            syn_shift = 1'b1;
            if (cnt == 7'(N-1)) begin
               next_state = TRAP;
            end
         end
         TRAP: begin
            if (clean || hit || last_trap) begin
               next_state = DONE;
            end else begin
               syn_unshift = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Result registers are only written when a verdict is reached, so they hold through IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cw_buf        <= '0;
         cnt           <= '0;
         j             <= '0;
         data_out      <= '0;
         corrected     <= 1'b0;
         uncorrectable <= 1'b0;
         err_pos       <= '0;
         err_burst     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  cw_buf <= cw_in;
                  cnt    <= '0;
                  j      <= '0;
               end
            end
            SYND: begin
               cnt <= cnt + 7'd1;
            end
            TRAP: begin
               if (clean) begin
                  data_out      <= cw_buf[N-1:R];
                  corrected     <= 1'b0;
                  uncorrectable <= 1'b0;
                  err_pos       <= '0;
                  err_burst     <= '0;
               end else if (hit) begin
                  cw_buf        <= cw_buf ^ fix;
                  data_out      <= cw_buf[N-1:R] ^ fix[N-1:R];
                  corrected     <= 1'b1;
                  uncorrectable <= 1'b0;
                  err_pos       <= j;
                  err_burst     <= syn[B-1:0];
               end else if (last_trap) begin
                  data_out      <= cw_buf[N-1:R];
                  corrected     <= 1'b0;
                  uncorrectable <= 1'b1;
                  err_pos       <= '0;
                  err_burst     <= '0;
               end else begin
                  j <= j + 6'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fire_decoder.sv
// Self-checking bench for fire_decoder: directed test-plan cases plus random bursts,
// compared against a polynomial-arithmetic reference model.
module tb_fire_decoder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] cw_in;
   logic        out_valid;
   logic        out_ready;
   logic [39:0] data_out;
   logic        corrected;
   logic        uncorrectable;
   logic [5:0]  err_pos;
   logic [7:0]  err_burst;

   int checks = 0;
   int errors = 0;

   logic [23:0] xm [0:63];
   logic        exp_clean;
   logic        exp_hit;
   logic        exp_unc;
   int          exp_pos;
   logic [7:0]  exp_b;
   logic [39:0] exp_data;
   int          exp_lat;
   int          last_lat;

   fire_decoder dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .cw_in         (cw_in),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .data_out      (data_out),
      .corrected     (corrected),
      .uncorrectable (uncorrectable),
      .err_pos       (err_pos),
      .err_burst     (err_burst)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Plain polynomial long division by g(x) = x^24+x^19+x^15+x^9+x^4+1.
   function automatic logic [23:0] polyMod(input logic [63:0] c);
      logic [63:0] r;
      logic [63:0] g;
      r = c;
      g = 64'h1088211;
      for (int k = 63; k >= 24; k--) begin
         if (r[k]) r = r ^ (g << (k - 24));
      end
      return r[23:0];
   endfunction

   // Remainder is linear, so sum the precomputed x^i mod g terms.
   function automatic logic [23:0] remOf(input logic [63:0] c);
      logic [23:0] acc;
      acc = '0;
      for (int i = 0; i < 64; i++) begin
         if (c[i]) acc = acc ^ xm[i];
      end
      return acc;
   endfunction

   function automatic logic [63:0] encode(input logic [39:0] m);
      logic [63:0] c;
      c = {m, 24'h0};
      c[23:0] = remOf(c);
      return c;
   endfunction

   // Smallest j with a burst b (inside the codeword) such that b*x^j has the same syndrome.
   task automatic runModel(input logic [63:0] cw);
      logic [23:0] s;
      logic [71:0] ext;
      logic [63:0] fixed;
      s = remOf(cw);
      exp_clean = (s == 24'h0);
      exp_hit   = 1'b0;
      exp_pos   = 0;
      exp_b     = 8'h0;
      if (!exp_clean) begin
         for (int jj = 0; jj < 64 && !exp_hit; jj++) begin
            for (int bv = 1; bv < 256 && !exp_hit; bv++) begin
               ext = 72'(bv) << jj;
               if (ext[71:64] == 8'h0 && remOf(ext[63:0]) == s) begin
                  exp_hit = 1'b1;
                  exp_pos = jj;
                  exp_b   = 8'(bv);
               end
            end
         end
      end
      exp_unc  = !exp_clean && !exp_hit;
      fixed    = cw ^ (64'(exp_b) << exp_pos);
      exp_data = fixed[63:24];
      exp_lat  = exp_clean ? 65 : (exp_hit ? 65 + exp_pos : 128);
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offers one codeword, measures latency, optionally stalls the consumer, then takes the result.
   task automatic applyStimulus(input logic [63:0] cw, input int hold);
      int guard;
      runModel(cw);
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      checkOutput("in_ready_before", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      cw_in    = cw;
      @(posedge clk); #1;
      in_valid = 1'b0;
      last_lat = 0;
      while (!out_valid && last_lat < 300) begin
         @(posedge clk); #1;
         last_lat++;
      end
      checkOutput("latency", 64'(last_lat), 64'(exp_lat));
      checkOutput("data_out", 64'(data_out), 64'(exp_data));
      checkOutput("corrected", 64'(corrected), 64'(exp_hit));
      checkOutput("uncorrectable", 64'(uncorrectable), 64'(exp_unc));
      checkOutput("err_pos", 64'(err_pos), 64'(exp_pos));
      checkOutput("err_burst", 64'(err_burst), 64'(exp_b));
      if (hold > 0) begin
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
         end
         checkOutput("hold_data", 64'(data_out), 64'(exp_data));
         checkOutput("hold_flags", {62'd0, corrected, uncorrectable}, {62'd0, exp_hit, exp_unc});
         checkOutput("hold_pos", {50'd0, err_pos, err_burst}, {50'd0, 6'(exp_pos), exp_b});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput("in_ready_after", 64'(in_ready), 64'd1);
      checkOutput("out_valid_drop", 64'(out_valid), 64'd0);
   endtask

   initial begin
      logic [63:0] clean_cw;
      logic [63:0] cw;
      int          kind;
      int          len;
      int          pos;
      int          p2;
      logic [7:0]  pat;

      for (int i = 0; i < 64; i++) xm[i] = polyMod(64'h1 << i);

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      cw_in     = '0;
      #12;
      checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_outputs", {22'd0, data_out, corrected, uncorrectable, err_pos, err_burst}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      clean_cw = encode(40'h12_3456_789A);
      checkOutput("model_clean_syndrome", 64'(remOf(clean_cw)), 64'd0);

      applyStimulus(clean_cw, 0);
      checkOutput("clean_data", 64'(data_out), 64'h12_3456_789A);
      checkOutput("clean_flags", {62'd0, corrected, uncorrectable}, 64'd0);
      checkOutput("clean_lat", 64'(last_lat), 64'd65);

      applyStimulus(clean_cw ^ 64'h8, 0);
      checkOutput("bit3_corr", 64'(corrected), 64'd1);
      checkOutput("bit3_pos", 64'(err_pos), 64'd0);
      checkOutput("bit3_burst", 64'(err_burst), 64'h08);
      checkOutput("bit3_data", 64'(data_out), 64'h12_3456_789A);
      checkOutput("bit3_lat", 64'(last_lat), 64'd65);

      applyStimulus(clean_cw ^ (64'h1 << 30), 0);
      checkOutput("bit30_pos", 64'(err_pos), 64'd23);
      checkOutput("bit30_burst", 64'(err_burst), 64'h80);
      checkOutput("bit30_corr", 64'(corrected), 64'd1);
      checkOutput("bit30_lat", 64'(last_lat), 64'd88);

      applyStimulus(clean_cw ^ (64'hFF << 45), 0);
      checkOutput("burst45_pos", 64'(err_pos), 64'd45);
      checkOutput("burst45_burst", 64'(err_burst), 64'hFF);
      checkOutput("burst45_data", 64'(data_out), 64'h12_3456_789A);

      applyStimulus(clean_cw ^ (64'hFF << 56), 20);
      checkOutput("burst56_pos", 64'(err_pos), 64'd56);
      checkOutput("burst56_burst", 64'(err_burst), 64'hFF);
      checkOutput("burst56_corr", 64'(corrected), 64'd1);

      // Abort a second codeword mid-syndrome with an asynchronous reset.
      in_valid = 1'b1;
      cw_in    = clean_cw ^ 64'h3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("midreset_in_ready", 64'(in_ready), 64'd1);
      checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("midreset_outputs", {22'd0, data_out, corrected, uncorrectable, err_pos, err_burst}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      cw = clean_cw ^ 64'h1 ^ (64'h1 << 40);
      applyStimulus(cw, 0);
      if (exp_unc) checkOutput("span41_raw", 64'(data_out), 64'(cw[63:24]));

      for (int t = 0; t < 12; t++) begin
         clean_cw = encode({$urandom, 8'($urandom)});
         kind = $urandom_range(0, 2);
         cw   = clean_cw;
         if (kind == 1) begin
            len = $urandom_range(1, 8);
            pos = $urandom_range(0, 64 - len);
            pat = 8'($urandom) & 8'((1 << len) - 1);
            pat = pat | 8'(1 << (len - 1)) | 8'h1;
            cw  = cw ^ (64'(pat) << pos);
         end else if (kind == 2) begin
            pos = $urandom_range(0, 50);
            p2  = $urandom_range(pos + 9, 63);
            cw  = cw ^ (64'h1 << pos) ^ (64'h1 << p2);
         end
         applyStimulus(cw, (t == 5) ? 7 : 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
